// File: rtl/ifid_queue_if.sv
// Fetch/decode handshake bundle for ifid_queue: fetch pushes {pc, instruction},
// decode sees the head entry. The queue itself uses the slave modport.
interface ifid_queue_if #(
  parameter int AW = 16,
  parameter int IW = 16
);
  logic          inValid;
  logic          inReady;
  logic [AW-1:0] pc;
  logic [IW-1:0] instruction;
  logic          ifidValid;
  logic [AW-1:0] ifidPC;
  logic [IW-1:0] ifidInstr;

  modport master (
    output inValid, pc, instruction,
    input  inReady, ifidValid, ifidPC, ifidInstr
  );

  modport slave (
    input  inValid, pc, instruction,
    output inReady, ifidValid, ifidPC, ifidInstr
  );
endinterface

// File: rtl/ifid_queue.sv
// IF/ID circular queue of DEPTH {pc, instruction} entries with flush and NOP-when-empty.
// Optional IFID_OCCUPANCY_EN adds occupancy and overflowAttempt outputs.
module ifid_queue #(
  parameter int            AW        = 16,
  parameter int            IW        = 16,
  parameter int            DEPTH     = 2,
  parameter logic [IW-1:0] NOP_INSTR = '0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic           stall,
  ifid_queue_if.slave    bus
`ifdef IFID_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   overflowAttempt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [CW-1:0] count;
  logic [AW-1:0] pcMem    [DEPTH];
  logic [IW-1:0] instrMem [DEPTH];

  logic full;
  logic notEmpty;
  logic push;
  logic pop;

  // Readiness depends on the current count only, so a full queue never takes a same-cycle push.
  assign full     = (count == CNT_MAX);
  assign notEmpty = (count != '0);
  assign push     = bus.inValid && !full && !flush;
  assign pop      = notEmpty && !stall && !flush;

  assign bus.inReady   = !full;
  assign bus.ifidValid = notEmpty;
  assign bus.ifidPC    = notEmpty ? pcMem[rdPtr]    : '0;
  assign bus.ifidInstr = notEmpty ? instrMem[rdPtr] : NOP_INSTR;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pcMem[i]    <= '0;
        instrMem[i] <= '0;
      end
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        pcMem[wrPtr]    <= bus.pc;
        instrMem[wrPtr] <= bus.instruction;
        wrPtr           <= wrPtr + PTR_ONE;
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
    end
  end

`ifdef IFID_OCCUPANCY_EN
  assign occupancy = count;

  // Flags a fetch that was turned away because the queue was full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflowAttempt <= 1'b0;
    end else begin
      overflowAttempt <= bus.inValid && full && !flush;
    end
  end
`endif

endmodule

// File: tb/tb_ifid_queue.sv
// Self-checking bench for ifid_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_ifid_queue;

  localparam int            AW    = 16;
  localparam int            IW    = 16;
  localparam int            DEPTH = 2;
  localparam logic [IW-1:0] NOP   = '0;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic stall = 1'b0;

  ifid_queue_if #(.AW(AW), .IW(IW)) bus ();

`ifdef IFID_OCCUPANCY_EN
  logic [1:0] occupancy;
  logic       overflowAttempt;
`endif

  ifid_queue #(
    .AW(AW), .IW(IW), .DEPTH(DEPTH), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .stall(stall),
    .bus(bus.slave)
`ifdef IFID_OCCUPANCY_EN
    ,
    .occupancy(occupancy),
    .overflowAttempt(overflowAttempt)
`endif
  );

  always #5 clk = ~clk;

  logic [AW+IW-1:0] mq[$];
  logic             ovfModel;
  int               nChecks = 0;
  int               nFails  = 0;
  logic [AW+IW+1:0] act;
  logic [AW+IW+1:0] exp;

  // Drive one cycle of inputs, advance one edge, and update the reference model.
  task automatic applyStimulus(input logic f, input logic s, input logic v,
                               input logic [AW-1:0] p, input logic [IW-1:0] i);
    bit rdy, pushOk, popOk;
    flush           = f;
    stall           = s;
    bus.inValid     = v;
    bus.pc          = p;
    bus.instruction = i;
    @(posedge clk);
    rdy      = (mq.size() < DEPTH);
    pushOk   = v && rdy && !f;
    popOk    = (mq.size() > 0) && !s && !f;
    ovfModel = v && !rdy && !f;
    if (f) begin
      mq.delete();
    end else begin
      if (popOk) void'(mq.pop_front());
      if (pushOk) mq.push_back({p, i});
    end
    #1;
  endtask

  function automatic logic [AW+IW+1:0] expOut();
    if (mq.size() > 0) return {1'b1, 1'(mq.size() < DEPTH), mq[0]};
    return {1'b0, 1'b1, {AW{1'b0}}, NOP};
  endfunction

  task automatic test_reset();
    #2;
    act = {bus.ifidValid, bus.inReady, bus.ifidPC, bus.ifidInstr};
    nChecks++;
    if (act !== {1'b0, 1'b1, 16'h0000, 16'h0000}) begin
      nFails++;
      $display("[TB] FAIL reset_initial: got %h required %h", act, {1'b0, 1'b1, 16'h0000, 16'h0000});
    end
    @(negedge clk);
    #2 reset = 1'b0;
    mq.delete();
    ovfModel = 1'b0;
    applyStimulus(0, 1, 1, 16'h0011, 16'h1234);
    applyStimulus(0, 1, 1, 16'h0013, 16'h5678);
    #3 reset = 1'b1;
    #1;
    act = {bus.ifidValid, bus.inReady, bus.ifidPC, bus.ifidInstr};
    nChecks++;
    if (act !== {1'b0, 1'b1, 16'h0000, 16'h0000}) begin
      nFails++;
      $display("[TB] FAIL reset_async: got %h required %h", act, {1'b0, 1'b1, 16'h0000, 16'h0000});
    end
`ifdef IFID_OCCUPANCY_EN
    nChecks++;
    if ({occupancy, overflowAttempt} !== 3'b000) begin
      nFails++;
      $display("[TB] FAIL reset_occupancy: got %b required 000", {occupancy, overflowAttempt});
    end
`endif
    mq.delete();
    ovfModel    = 1'b0;
    bus.inValid = 1'b0;
    stall       = 1'b0;
    #2 reset = 1'b0;
  endtask

  task automatic test_single();
    applyStimulus(0, 0, 1, 16'h0101, 16'hAAAA);
    act = {bus.ifidValid, bus.inReady, bus.ifidPC, bus.ifidInstr};
    nChecks++;
    if (act !== {1'b1, 1'b1, 16'h0101, 16'hAAAA}) begin
      nFails++;
      $display("[TB] FAIL single_push: got %h required %h", act, {1'b1, 1'b1, 16'h0101, 16'hAAAA});
    end
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
    act = {bus.ifidValid, bus.inReady, bus.ifidPC, bus.ifidInstr};
    nChecks++;
    if (act !== {1'b0, 1'b1, 16'h0000, 16'h0000}) begin
      nFails++;
      $display("[TB] FAIL single_drain: got %h required %h", act, {1'b0, 1'b1, 16'h0000, 16'h0000});
    end
  endtask

  task automatic test_stall_full();
    logic [AW+IW+1:0] req [5];
    req[0] = {1'b1, 1'b1, 16'h0100, 16'h1111};
    req[1] = {1'b1, 1'b0, 16'h0100, 16'h1111};
    req[2] = {1'b1, 1'b0, 16'h0100, 16'h1111};
    req[3] = {1'b1, 1'b1, 16'h0102, 16'h2222};
    req[4] = {1'b0, 1'b1, 16'h0000, 16'h0000};
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: applyStimulus(0, 1, 1, 16'h0100, 16'h1111);
        1: applyStimulus(0, 1, 1, 16'h0102, 16'h2222);
        2: applyStimulus(0, 1, 1, 16'h0104, 16'h3333);
        default: applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
      endcase
      act = {bus.ifidValid, bus.inReady, bus.ifidPC, bus.ifidInstr};
      nChecks++;
      if (act !== req[k]) begin
        nFails++;
        $display("[TB] FAIL stall_full step %0d: got %h required %h", k, act, req[k]);
      end
    end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 0, 1, 16'(16'h0100 + 2 * k), 16'(k));
      act = {bus.ifidValid, bus.inReady, bus.ifidPC, bus.ifidInstr};
      exp = {1'b1, 1'b1, 16'(16'h0100 + 2 * k), 16'(k)};
      nChecks++;
      if (act !== exp) begin
        nFails++;
        $display("[TB] FAIL wrap step %0d: got %h required %h", k, act, exp);
      end
    end
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
  endtask

  task automatic test_flush();
    applyStimulus(0, 1, 1, 16'h0150, 16'hC0C0);
    applyStimulus(0, 1, 1, 16'h0152, 16'hC1C1);
    nChecks++;
    if (bus.inReady !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL flush_prefill_ready: got %b required 0", bus.inReady);
    end
    applyStimulus(1, 1, 1, 16'h0200, 16'hBBBB);
    for (int k = 0; k < 2; k++) begin
      act = {bus.ifidValid, bus.inReady, bus.ifidPC, bus.ifidInstr};
      nChecks++;
      if (act !== {1'b0, 1'b1, 16'h0000, 16'h0000}) begin
        nFails++;
        $display("[TB] FAIL flush step %0d: got %h required %h", k, act, {1'b0, 1'b1, 16'h0000, 16'h0000});
      end
      applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
    end
  endtask

`ifdef IFID_OCCUPANCY_EN
  task automatic test_occupancy();
    logic [2:0] req [5];
    req[0] = 3'b010;
    req[1] = 3'b100;
    req[2] = 3'b101;
    req[3] = 3'b101;
    req[4] = 3'b000;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(k == 4, 1, 1, 16'(16'h0300 + k), 16'(16'hD000 + k));
      nChecks++;
      if ({occupancy, overflowAttempt} !== req[k]) begin
        nFails++;
        $display("[TB] FAIL occupancy step %0d: got %b required %b", k, {occupancy, overflowAttempt}, req[k]);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic f, s, v;
    for (int n = 0; n < 400; n++) begin
      f = ($urandom_range(0, 15) == 0);
      s = ($urandom_range(0, 2) == 0);
      v = ($urandom_range(0, 3) != 0);
      applyStimulus(f, s, v, 16'($urandom), 16'($urandom));
      act = {bus.ifidValid, bus.inReady, bus.ifidPC, bus.ifidInstr};
      exp = expOut();
      nChecks++;
      if (act !== exp) begin
        nFails++;
        $display("[TB] FAIL random cycle %0d: got %h required %h", n, act, exp);
      end
`ifdef IFID_OCCUPANCY_EN
      nChecks++;
      if ({occupancy, overflowAttempt} !== {2'(mq.size()), ovfModel}) begin
        nFails++;
        $display("[TB] FAIL random_occ cycle %0d: got %b required %b", n,
                 {occupancy, overflowAttempt}, {2'(mq.size()), ovfModel});
      end
`endif
    end
  endtask

  initial begin
    bus.inValid     = 1'b0;
    bus.pc          = '0;
    bus.instruction = '0;
    ovfModel        = 1'b0;
    test_reset();
    test_single();
    test_stall_full();
    test_wrap();
    test_flush();
`ifdef IFID_OCCUPANCY_EN
    test_occupancy();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
